// File: rtl/stack_pkg.sv
// Shared widths, op encodings, FSM states and per-op helpers for the stack sequencer.
package stack_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int PC_WIDTH    = 32;
  localparam int SP_WIDTH    = 11;
  localparam int FLAGS_WIDTH = 4;

  localparam logic [SP_WIDTH-1:0] SP_RESET = 11'd2047;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_INT  = 3'b101;
  localparam logic [2:0] OP_RTI  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_W,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_FL,
    ST_POP_W,
    ST_POP_FL,
    ST_POP_PCL,
    ST_POP_PCH
  } state_t;

  function automatic logic [1:0] op_beats(input logic [2:0] op);
    case (op)
      OP_PUSH, OP_POP: op_beats = 2'd1;
      OP_CALL, OP_RET: op_beats = 2'd2;
      OP_INT, OP_RTI:  op_beats = 2'd3;
      default:         op_beats = 2'd0;
    endcase
  endfunction

  function automatic logic is_push_op(input logic [2:0] op);
    is_push_op = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  function automatic logic is_pop_op(input logic [2:0] op);
    is_pop_op = (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Op request, result and data-memory signals between control, the sequencer and memory.
interface stack_sequencer_if;
  import stack_pkg::*;

  logic                   op_valid;
  logic [2:0]             op_code;
  logic [DATA_WIDTH-1:0]  push_data;
  logic [PC_WIDTH-1:0]    pc_in;
  logic [FLAGS_WIDTH-1:0] flags_in;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   busy;
  logic                   mem_push;
  logic                   mem_pop;
  logic [SP_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [SP_WIDTH-1:0]    sp;
  logic [DATA_WIDTH-1:0]  pop_data;
  logic                   pop_valid;
  logic [PC_WIDTH-1:0]    pc_out;
  logic                   pc_valid;
  logic [FLAGS_WIDTH-1:0] flags_out;
  logic                   flags_valid;
  logic                   stack_overflow;
  logic                   stack_underflow;

  modport slave (
    input  op_valid, op_code, push_data, pc_in, flags_in, mem_rdata,
    output busy, mem_push, mem_pop, mem_addr, mem_wdata, sp,
           pop_data, pop_valid, pc_out, pc_valid, flags_out, flags_valid,
           stack_overflow, stack_underflow
  );

  modport master (
    output op_valid, op_code, push_data, pc_in, flags_in, mem_rdata,
    input  busy, mem_push, mem_pop, mem_addr, mem_wdata, sp,
           pop_data, pop_valid, pc_out, pc_valid, flags_out, flags_valid,
           stack_overflow, stack_underflow
  );

endinterface

// File: rtl/stack_depth_check.sv
// Decides whether an op fits the stack: push-type ops need sp >= beats, pop-type need used >= beats.
module stack_depth_check
  import stack_pkg::*;
(
  input  logic [SP_WIDTH-1:0] sp,
  input  logic [2:0]          op_code,
  output logic                ok,
  output logic                overflow,
  output logic                underflow
);

  logic [SP_WIDTH-1:0] w_used;
  logic [SP_WIDTH-1:0] w_beats;

  assign w_used    = SP_RESET - sp;
  assign w_beats   = SP_WIDTH'(op_beats(op_code));
  assign overflow  = is_push_op(op_code) && (sp < w_beats);
  assign underflow = is_pop_op(op_code) && (w_used < w_beats);
  assign ok        = !overflow && !underflow;

endmodule

// File: rtl/stack_sequencer.sv
// Stack traffic sequencer: owns sp and issues one push/pop beat per cycle for PUSH/POP/CALL/RET/INT/RTI.
module stack_sequencer
  import stack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  stack_sequencer_if.slave  bus
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SP_WIDTH-1:0]    r_sp;
  logic [2:0]             r_op;
  logic [DATA_WIDTH-1:0]  r_push_data;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [FLAGS_WIDTH-1:0] r_flags;
  logic [DATA_WIDTH-1:0]  r_pc_lo;
  logic [FLAGS_WIDTH-1:0] r_flags_pop;

  logic [DATA_WIDTH-1:0]  r_pop_data;
  logic                   r_pop_valid;
  logic [PC_WIDTH-1:0]    r_pc_out;
  logic                   r_pc_valid;
  logic [FLAGS_WIDTH-1:0] r_flags_out;
  logic                   r_flags_valid;
  logic                   r_overflow;
  logic                   r_underflow;

  logic                   w_is_op;
  logic                   w_accept;
  logic                   w_ok;
  logic                   w_ovf;
  logic                   w_unf;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_wdata;

  stack_depth_check u_depth (
    .sp        (r_sp),
    .op_code   (bus.op_code),
    .ok        (w_ok),
    .overflow  (w_ovf),
    .underflow (w_unf)
  );

  assign w_is_op  = (bus.op_code != OP_NOP) && (bus.op_code != OP_RSVD);
  assign w_accept = (r_state == ST_IDLE) && bus.op_valid && w_is_op;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_wdata      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_ok) begin
          case (bus.op_code)
            OP_PUSH:        w_next_state = ST_PUSH_W;
            OP_CALL, OP_INT: w_next_state = ST_PUSH_PCH;
            OP_POP:         w_next_state = ST_POP_W;
            OP_RET:         w_next_state = ST_POP_PCL;
            OP_RTI:         w_next_state = ST_POP_FL;
            default:        w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_PUSH_W: begin
        w_push       = 1'b1;
        w_wdata      = r_push_data;
        w_next_state = ST_IDLE;
      end
      // PC high word goes first so the low word ends up on top
      ST_PUSH_PCH: begin
        w_push       = 1'b1;
        w_wdata      = r_pc[PC_WIDTH-1:DATA_WIDTH];
        w_next_state = ST_PUSH_PCL;
      end
      ST_PUSH_PCL: begin
        w_push       = 1'b1;
        w_wdata      = r_pc[DATA_WIDTH-1:0];
        w_next_state = (r_op == OP_INT) ? ST_PUSH_FL : ST_IDLE;
      end
      ST_PUSH_FL: begin
        w_push       = 1'b1;
        w_wdata      = {{(DATA_WIDTH-FLAGS_WIDTH){1'b0}}, r_flags};
        w_next_state = ST_IDLE;
      end
      ST_POP_W: begin
        w_pop        = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_POP_FL: begin
        w_pop        = 1'b1;
        w_next_state = ST_POP_PCL;
      end
      ST_POP_PCL: begin
        w_pop        = 1'b1;
        w_next_state = ST_POP_PCH;
      end
      ST_POP_PCH: begin
        w_pop        = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp          <= SP_RESET;
      r_op          <= OP_NOP;
      r_push_data   <= '0;
      r_pc          <= '0;
      r_flags       <= '0;
      r_pc_lo       <= '0;
      r_flags_pop   <= '0;
      r_pop_data    <= '0;
      r_pop_valid   <= 1'b0;
      r_pc_out      <= '0;
      r_pc_valid    <= 1'b0;
      r_flags_out   <= '0;
      r_flags_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_pop_valid   <= 1'b0;
      r_pc_valid    <= 1'b0;
      r_flags_valid <= 1'b0;
      r_overflow    <= w_accept && w_ovf;
      r_underflow   <= w_accept && w_unf;

      if (w_accept) begin
        r_op        <= bus.op_code;
        r_push_data <= bus.push_data;
        r_pc        <= bus.pc_in;
        r_flags     <= bus.flags_in;
      end

      if (w_push)     r_sp <= r_sp - SP_WIDTH'(1);
      else if (w_pop) r_sp <= r_sp + SP_WIDTH'(1);

      case (r_state)
        ST_POP_W: begin
          r_pop_data  <= bus.mem_rdata;
          r_pop_valid <= 1'b1;
        end
        ST_POP_FL:  r_flags_pop <= bus.mem_rdata[FLAGS_WIDTH-1:0];
        ST_POP_PCL: r_pc_lo     <= bus.mem_rdata;
        ST_POP_PCH: begin
          r_pc_out   <= {bus.mem_rdata, r_pc_lo};
          r_pc_valid <= 1'b1;
          if (r_op == OP_RTI) begin
            r_flags_out   <= r_flags_pop;
            r_flags_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy            = (r_state != ST_IDLE) || w_accept;
  assign bus.mem_push        = w_push;
  assign bus.mem_pop         = w_pop;
  assign bus.mem_addr        = w_push ? (r_sp - SP_WIDTH'(1)) : r_sp;
  assign bus.mem_wdata       = w_wdata;
  assign bus.sp              = r_sp;
  assign bus.pop_data        = r_pop_data;
  assign bus.pop_valid       = r_pop_valid;
  assign bus.pc_out          = r_pc_out;
  assign bus.pc_valid        = r_pc_valid;
  assign bus.flags_out       = r_flags_out;
  assign bus.flags_valid     = r_flags_valid;
  assign bus.stack_overflow  = r_overflow;
  assign bus.stack_underflow = r_underflow;

endmodule
